// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared fetch-stage constants and exception codes
package ifu_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BYTES_DEF   = 32'h0000_2000;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

endpackage

// File: rtl/ifu_fetch_ifid_reg.sv
// rtl/ifu_fetch_ifid_reg.sv - IF/ID pipeline register with load/hold/flush
module ifid_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc8,
    input  logic        in_bd,
    input  logic [4:0]  in_exc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_bd,
    output logic [4:0]  d_exc
);

    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_pc8_q, d_pc8_d;
    logic        d_valid_q, d_valid_d;
    logic        d_bd_q, d_bd_d;
    logic [4:0]  d_exc_q, d_exc_d;

    // Flush beats load; neither asserted means hold.
    always_comb begin
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_pc8_d   = d_pc8_q;
        d_valid_d = d_valid_q;
        d_bd_d    = d_bd_q;
        d_exc_d   = d_exc_q;
        if (flush) begin
            d_instr_d = 32'd0;
            d_pc_d    = 32'd0;
            d_pc8_d   = 32'd0;
            d_valid_d = 1'b0;
            d_bd_d    = 1'b0;
            d_exc_d   = 5'd0;
        end else if (load) begin
            d_instr_d = in_instr;
            d_pc_d    = in_pc;
            d_pc8_d   = in_pc8;
            d_valid_d = 1'b1;
            d_bd_d    = in_bd;
            d_exc_d   = in_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr_q <= 32'd0;
            d_pc_q    <= 32'd0;
            d_pc8_q   <= 32'd0;
            d_valid_q <= 1'b0;
            d_bd_q    <= 1'b0;
            d_exc_q   <= 5'd0;
        end else begin
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_pc8_q   <= d_pc8_d;
            d_valid_q <= d_valid_d;
            d_bd_q    <= d_bd_d;
            d_exc_q   <= d_exc_d;
        end
    end

    assign d_instr = d_instr_q;
    assign d_pc    = d_pc_q;
    assign d_pc8   = d_pc8_q;
    assign d_valid = d_valid_q;
    assign d_bd    = d_bd_q;
    assign d_exc   = d_exc_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC register, next-PC mux and IF/ID feed; FETCH_ADEL_CHECK_EN enables fetch AdEL detection
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] IM_BYTES   = IM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        d_is_branch,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        d_bd,
    output logic [4:0]  d_exc
);

    logic [31:0] pc_q, pc_d;
    logic        ifid_load;
    logic        ifid_flush;
    logic        ifid_bd;
    logic [31:0] fetch_instr;
    logic [4:0]  fetch_exc;

    assign im_addr = pc_q - IM_BASE;
    assign f_pc    = pc_q;

`ifdef FETCH_ADEL_CHECK_EN
    logic adel;
    assign adel        = (pc_q[1:0] != 2'b00) || (im_addr >= IM_BYTES);
    assign fetch_instr = adel ? 32'd0 : im_instr;
    assign fetch_exc   = adel ? EXC_ADEL : EXC_NONE;
`else
    assign fetch_instr = im_instr;
    assign fetch_exc   = EXC_NONE;
`endif

    // Priority: exc > eret > stall > redirect > sequential. Reset handled in the flop.
    always_comb begin
        pc_d       = pc_q + 32'd4;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_bd    = d_is_branch;
        if (exc_req) begin
            pc_d       = HANDLER_PC;
            ifid_flush = 1'b1;
        end else if (eret_req) begin
            pc_d       = epc;
            ifid_flush = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            // The word fetched this cycle is the delay slot of the redirecting branch.
            pc_d      = redirect_pc;
            ifid_load = 1'b1;
            ifid_bd   = 1'b1;
        end else begin
            ifid_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .in_instr (fetch_instr),
        .in_pc    (pc_q),
        .in_pc8   (pc_q + 32'd8),
        .in_bd    (ifid_bd),
        .in_exc   (fetch_exc),
        .d_instr  (d_instr),
        .d_pc     (d_pc),
        .d_pc8    (d_pc8),
        .d_valid  (d_valid),
        .d_bd     (d_bd),
        .d_exc    (d_exc)
    );

endmodule
